// File: rtl/tt_frame_trigger.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tt_frame_trigger
//  Function : Time-triggered frame-start scheduler. Emits bursts of frame
//             requests over valid/ready and flags bursts that overrun.
//  Revision : 1.0  initial release
// ============================================================================
module tt_frame_trigger #(
    parameter int PERIOD    = 1000,
    parameter int OFFSET    = 100,
    parameter int FRAME_NUM = 4,
    parameter int GAP       = 5
) (
    input  logic        sync_clk,
    input  logic        rst,
    input  logic [31:0] top_time,
    input  logic        cfg_en,
    output logic        trig_valid,
    input  logic        trig_ready,
    output logic [7:0]  trig_frame_idx,
    output logic [15:0] trig_cycle_cnt,
    output logic [31:0] trig_timestamp,
    output logic        overrun_pulse,
    output logic        busy
);

    localparam int              GAP_W      = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GAP_W-1:0] c_GAP_LOAD = (GAP > 0) ? GAP_W'(GAP - 1) : '0;
    localparam logic [31:0]     c_PERIOD   = 32'(PERIOD);
    localparam logic [31:0]     c_OFFSET   = 32'(OFFSET);
    localparam logic [7:0]      c_LAST_IDX = 8'(FRAME_NUM - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_SEND = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    state_t           state_q,     state_d;
    logic [31:0]      next_trig_q, next_trig_d;
    logic             en_d_q,      en_d_d;
    logic [7:0]       frame_idx_q, frame_idx_d;
    logic [15:0]      cycle_cnt_q, cycle_cnt_d;
    logic [31:0]      timestamp_q, timestamp_d;
    logic             overrun_q,   overrun_d;
    logic [GAP_W-1:0] gap_cnt_q,   gap_cnt_d;
    logic             gap_last_q,  gap_last_d;

    logic [31:0] w_diff;
    logic        w_due;

    // Signed difference keeps the comparison correct across the 32-bit rollover.
    assign w_diff = top_time - next_trig_q;
    assign w_due  = ~w_diff[31];

    always_comb begin
        state_d     = state_q;
        next_trig_d = next_trig_q;
        en_d_d      = cfg_en;
        frame_idx_d = frame_idx_q;
        cycle_cnt_d = cycle_cnt_q;
        timestamp_d = timestamp_q;
        overrun_d   = 1'b0;
        gap_cnt_d   = gap_cnt_q;
        gap_last_d  = gap_last_q;

        if (!cfg_en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!en_d_q) begin
                        next_trig_d = top_time + c_OFFSET;
                        state_d     = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_due) begin
                        state_d     = ST_SEND;
                        timestamp_d = next_trig_q;
                        frame_idx_d = 8'd0;
                        next_trig_d = next_trig_q + c_PERIOD;
                    end
                end
                ST_SEND: begin
                    if (trig_ready) begin
                        gap_cnt_d = c_GAP_LOAD;
                        if (frame_idx_q == c_LAST_IDX) begin
                            cycle_cnt_d = cycle_cnt_q + 16'd1;
                            gap_last_d  = 1'b1;
                            state_d     = (GAP > 0) ? ST_GAP : ST_WAIT;
                        end else begin
                            frame_idx_d = frame_idx_q + 8'd1;
                            gap_last_d  = 1'b0;
                            state_d     = (GAP > 0) ? ST_GAP : ST_SEND;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == '0) begin
                        state_d = gap_last_q ? ST_WAIT : ST_SEND;
                    end else begin
                        gap_cnt_d = gap_cnt_q - GAP_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            // A start that arrives mid-burst is dropped, not queued.
            if ((state_q == ST_SEND || state_q == ST_GAP) && w_due) begin
                overrun_d   = 1'b1;
                next_trig_d = next_trig_q + c_PERIOD;
            end
        end
    end

    always_ff @(posedge sync_clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            next_trig_q <= '0;
            en_d_q      <= 1'b0;
            frame_idx_q <= '0;
            cycle_cnt_q <= '0;
            timestamp_q <= '0;
            overrun_q   <= 1'b0;
            gap_cnt_q   <= '0;
            gap_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            next_trig_q <= next_trig_d;
            en_d_q      <= en_d_d;
            frame_idx_q <= frame_idx_d;
            cycle_cnt_q <= cycle_cnt_d;
            timestamp_q <= timestamp_d;
            overrun_q   <= overrun_d;
            gap_cnt_q   <= gap_cnt_d;
            gap_last_q  <= gap_last_d;
        end
    end

    assign trig_valid     = (state_q == ST_SEND);
    assign busy           = (state_q == ST_SEND) || (state_q == ST_GAP);
    assign trig_frame_idx = frame_idx_q;
    assign trig_cycle_cnt = cycle_cnt_q;
    assign trig_timestamp = timestamp_q;
    assign overrun_pulse  = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_tt_frame_trigger.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_tt_frame_trigger
//  Function : Scoreboard bench for tt_frame_trigger (default and short-period
//             instances sharing clock, reset and time base).
//  Revision : 1.0  initial release
// ============================================================================
module tb_tt_frame_trigger;

    logic        sync_clk = 1'b0;
    logic        rst;
    logic [31:0] top_time;
    logic        cfg_en, cfg_en_o;
    logic        trig_ready, trig_ready_o;

    logic        trig_valid, busy, overrun_pulse;
    logic [7:0]  trig_frame_idx;
    logic [15:0] trig_cycle_cnt;
    logic [31:0] trig_timestamp;

    logic        trig_valid_o, busy_o, overrun_pulse_o;
    logic [7:0]  trig_frame_idx_o;
    logic [15:0] trig_cycle_cnt_o;
    logic [31:0] trig_timestamp_o;

    always #4 sync_clk = ~sync_clk;

    tt_frame_trigger #(.PERIOD(1000), .OFFSET(100), .FRAME_NUM(4), .GAP(5)) u_dut (
        .sync_clk       (sync_clk),
        .rst            (rst),
        .top_time       (top_time),
        .cfg_en         (cfg_en),
        .trig_valid     (trig_valid),
        .trig_ready     (trig_ready),
        .trig_frame_idx (trig_frame_idx),
        .trig_cycle_cnt (trig_cycle_cnt),
        .trig_timestamp (trig_timestamp),
        .overrun_pulse  (overrun_pulse),
        .busy           (busy)
    );

    tt_frame_trigger #(.PERIOD(10), .OFFSET(3), .FRAME_NUM(4), .GAP(5)) u_ovr (
        .sync_clk       (sync_clk),
        .rst            (rst),
        .top_time       (top_time),
        .cfg_en         (cfg_en_o),
        .trig_valid     (trig_valid_o),
        .trig_ready     (trig_ready_o),
        .trig_frame_idx (trig_frame_idx_o),
        .trig_cycle_cnt (trig_cycle_cnt_o),
        .trig_timestamp (trig_timestamp_o),
        .overrun_pulse  (overrun_pulse_o),
        .busy           (busy_o)
    );

    typedef struct packed {
        logic [7:0]  idx;
        logic [15:0] cnt;
        logic [31:0] ts;
        logic [31:0] top;
    } exp_t;

    exp_t        q_main[$];
    exp_t        q_ovr[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] lo_s  = '0;
    logic [31:0] lo_e  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Inputs change 1 ns after the active edge; ready is low inside [lo_s, lo_e).
    task automatic step();
        @(posedge sync_clk);
        #1;
        top_time   = top_time + 32'd1;
        trig_ready = !(top_time >= lo_s && top_time < lo_e);
    endtask

    task automatic step_to(input logic [31:0] t);
        @(posedge sync_clk);
        #1;
        top_time   = t;
        trig_ready = !(top_time >= lo_s && top_time < lo_e);
    endtask

    task automatic run_until(input logic [31:0] t, output int vcnt);
        int guard;
        vcnt  = 0;
        guard = 0;
        while (top_time != t && guard < 3000) begin
            step();
            guard++;
            if (trig_valid) vcnt++;
        end
        if (top_time != t) begin
            n_cmp++;
            n_err++;
            $display("FAIL run_until: actual top_time %0h required %0h", top_time, t);
        end
    endtask

    task automatic push_main(input logic [7:0] idx, input logic [15:0] cnt,
                             input logic [31:0] ts, input logic [31:0] top);
        q_main.push_back('{idx: idx, cnt: cnt, ts: ts, top: top});
    endtask

    task automatic push_ovr(input logic [7:0] idx, input logic [15:0] cnt,
                            input logic [31:0] ts, input logic [31:0] top);
        q_ovr.push_back('{idx: idx, cnt: cnt, ts: ts, top: top});
    endtask

    always @(negedge sync_clk) begin : mon_main
        exp_t e;
        if (trig_valid && trig_ready) begin
            n_cmp++;
            if (q_main.size() == 0) begin
                n_err++;
                $display("FAIL main_unexpected: actual idx %0d ts %0h at top %0h, required no request",
                         trig_frame_idx, trig_timestamp, top_time);
            end else begin
                e = q_main.pop_front();
                if (trig_frame_idx !== e.idx || trig_cycle_cnt !== e.cnt ||
                    trig_timestamp !== e.ts || top_time !== e.top) begin
                    n_err++;
                    $display("FAIL main_req: actual idx %0d cnt %0d ts %0h top %0h, required idx %0d cnt %0d ts %0h top %0h",
                             trig_frame_idx, trig_cycle_cnt, trig_timestamp, top_time,
                             e.idx, e.cnt, e.ts, e.top);
                end
            end
        end
        if (overrun_pulse) begin
            n_cmp++;
            n_err++;
            $display("FAIL main_overrun: actual pulse at top %0h, required none", top_time);
        end
    end

    always @(negedge sync_clk) begin : mon_ovr
        exp_t e;
        if (trig_valid_o && trig_ready_o) begin
            n_cmp++;
            if (q_ovr.size() == 0) begin
                n_err++;
                $display("FAIL ovr_unexpected: actual idx %0d ts %0h at top %0h, required no request",
                         trig_frame_idx_o, trig_timestamp_o, top_time);
            end else begin
                e = q_ovr.pop_front();
                if (trig_frame_idx_o !== e.idx || trig_cycle_cnt_o !== e.cnt ||
                    trig_timestamp_o !== e.ts || top_time !== e.top) begin
                    n_err++;
                    $display("FAIL ovr_req: actual idx %0d cnt %0d ts %0h top %0h, required idx %0d cnt %0d ts %0h top %0h",
                             trig_frame_idx_o, trig_cycle_cnt_o, trig_timestamp_o, top_time,
                             e.idx, e.cnt, e.ts, e.top);
                end
            end
        end
    end

    initial begin
        int          v;
        int          bad;
        int          k;
        int          guard;
        logic [31:0] ov_exp [4];

        rst          = 1'b1;
        cfg_en       = 1'b0;
        cfg_en_o     = 1'b0;
        top_time     = '0;
        trig_ready   = 1'b1;
        trig_ready_o = 1'b1;
        repeat (3) step();

        check("rst_valid",   {31'd0, trig_valid},    32'd0);
        check("rst_busy",    {31'd0, busy},          32'd0);
        check("rst_idx",     {24'd0, trig_frame_idx}, 32'd0);
        check("rst_cnt",     {16'd0, trig_cycle_cnt}, 32'd0);
        check("rst_ts",      trig_timestamp,         32'd0);
        check("rst_overrun", {31'd0, overrun_pulse}, 32'd0);
        check("rst_ovr_busy", {31'd0, busy_o},       32'd0);
        rst = 1'b0;

        // Two nominal bursts: arm at 200, starts at 300 and 1300.
        step_to(32'd200);
        cfg_en = 1'b1;
        for (int i = 0; i < 4; i++) push_main(8'(i), 16'd0, 32'd300,  32'd301  + 32'(6 * i));
        for (int i = 0; i < 4; i++) push_main(8'(i), 16'd1, 32'd1300, 32'd1301 + 32'(6 * i));
        run_until(32'd1325, v);
        check("nom_queue_left", q_main.size(), 32'd0);
        check("nom_cycle_cnt",  {16'd0, trig_cycle_cnt}, 32'd2);

        // Backpressure on frame 1 of the burst at 2300.
        lo_s = 32'd2307;
        lo_e = 32'd2327;
        push_main(8'd0, 16'd2, 32'd2300, 32'd2301);
        push_main(8'd1, 16'd2, 32'd2300, 32'd2327);
        push_main(8'd2, 16'd2, 32'd2300, 32'd2333);
        push_main(8'd3, 16'd2, 32'd2300, 32'd2339);
        run_until(32'd2306, v);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!(trig_valid && trig_frame_idx == 8'd1 && trig_timestamp == 32'd2300 &&
                  trig_cycle_cnt == 16'd2)) bad++;
        end
        check("bp_unstable_cycles", bad, 32'd0);
        run_until(32'd2345, v);
        check("bp_queue_left", q_main.size(), 32'd0);
        check("bp_cycle_cnt",  {16'd0, trig_cycle_cnt}, 32'd3);

        // Disable while a request is stalled, then re-arm at 3310.
        lo_s = 32'd3301;
        lo_e = 32'd3310;
        run_until(32'd3303, v);
        check("dis_valid_before", {31'd0, trig_valid}, 32'd1);
        cfg_en = 1'b0;
        step();
        check("dis_valid", {31'd0, trig_valid}, 32'd0);
        check("dis_busy",  {31'd0, busy},       32'd0);
        check("dis_ts",    trig_timestamp,      32'd3300);
        check("dis_cnt",   {16'd0, trig_cycle_cnt}, 32'd3);
        run_until(32'd3310, v);
        cfg_en = 1'b1;
        for (int i = 0; i < 4; i++) push_main(8'(i), 16'd3, 32'd3410, 32'd3411 + 32'(6 * i));
        run_until(32'd3435, v);
        check("rearm_queue_left", q_main.size(), 32'd0);
        check("rearm_cycle_cnt",  {16'd0, trig_cycle_cnt}, 32'd4);

        // Reset during the gap after frame 0 of the burst at 4410.
        push_main(8'd0, 16'd4, 32'd4410, 32'd4411);
        run_until(32'd4413, v);
        check("gap_busy",  {31'd0, busy},       32'd1);
        check("gap_valid", {31'd0, trig_valid}, 32'd0);
        rst    = 1'b1;
        cfg_en = 1'b0;
        step();
        rst = 1'b0;
        check("mrst_busy", {31'd0, busy},           32'd0);
        check("mrst_idx",  {24'd0, trig_frame_idx}, 32'd0);
        check("mrst_cnt",  {16'd0, trig_cycle_cnt}, 32'd0);
        check("mrst_ts",   trig_timestamp,          32'd0);
        run_until(32'd4500, v);
        check("mrst_quiet_valid_cycles", v, 32'd0);
        cfg_en = 1'b1;
        for (int i = 0; i < 4; i++) push_main(8'(i), 16'd0, 32'd4600, 32'd4601 + 32'(6 * i));
        run_until(32'd4625, v);
        check("mrst_queue_left", q_main.size(), 32'd0);
        check("mrst_cycle_cnt",  {16'd0, trig_cycle_cnt}, 32'd1);

        // Arm just before the 32-bit rollover.
        cfg_en = 1'b0;
        step();
        step();
        step_to(32'hFFFF_FFC0);
        cfg_en = 1'b1;
        for (int i = 0; i < 4; i++) push_main(8'(i), 16'd1, 32'h24, 32'h25 + 32'(6 * i));
        run_until(32'h24, v);
        check("wrap_early_valid_cycles", v, 32'd0);
        run_until(32'h40, v);
        check("wrap_queue_left", q_main.size(), 32'd0);
        check("wrap_cycle_cnt",  {16'd0, trig_cycle_cnt}, 32'd2);

        // Short-period instance: bursts last 19 ticks against a 10-tick period.
        cfg_en = 1'b0;
        step();
        step_to(32'd1000);
        cfg_en_o = 1'b1;
        for (int i = 0; i < 4; i++) push_ovr(8'(i), 16'd0, 32'd1003, 32'd1004 + 32'(6 * i));
        for (int i = 0; i < 4; i++) push_ovr(8'(i), 16'd1, 32'd1033, 32'd1034 + 32'(6 * i));
        ov_exp[0] = 32'd1014;
        ov_exp[1] = 32'd1024;
        ov_exp[2] = 32'd1044;
        ov_exp[3] = 32'd1054;
        k     = 0;
        guard = 0;
        while (top_time != 32'd1058 && guard < 200) begin
            step();
            guard++;
            if (overrun_pulse_o) begin
                if (k < 4) begin
                    check("ovr_pulse_time", top_time, ov_exp[k]);
                end else begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL ovr_extra_pulse: actual pulse at top %0h, required none", top_time);
                end
                k++;
            end
        end
        check("ovr_pulse_count", k, 32'd4);
        check("ovr_queue_left",  q_ovr.size(), 32'd0);
        check("ovr_cycle_cnt",   {16'd0, trig_cycle_cnt_o}, 32'd2);
        check("ovr_busy_wait",   {31'd0, busy_o}, 32'd0);
        cfg_en_o = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tt_frame_trigger.md
Name: tt_frame_trigger

Overview:
- Consumer of the free-running 32-bit time base `top_time`, which increments once per `sync_clk` cycle.
- Issues time-triggered frame-start requests to the downstream frame transmitter over a valid/ready handshake. Each burst is FRAME_NUM requests, spaced by an inter-frame gap, once every PERIOD ticks, starting OFFSET ticks after enable.
- Flags bursts that overrun their period.

Parameters:
- PERIOD, 1000: ticks between burst starts; legal range 1..2^31-1.
- OFFSET, 100: ticks from enable to the first burst start.
- FRAME_NUM, 4: requests per burst; legal range 1..255.
- GAP, 5: idle cycles after each accepted request; 0 means back-to-back.

Ports:
- sync_clk  in  1  system clock, 125 MHz.
- rst  in  1  synchronous reset, active-high.
- top_time  in  32  free-running time base.
- cfg_en  in  1  enable; a rising edge arms the scheduler; low stops it.
- trig_valid  out  1  frame-start request valid.
- trig_ready  in  1  transmitter accepts the request.
- trig_frame_idx  out  8  index of the frame within the burst, 0..FRAME_NUM-1.
- trig_cycle_cnt  out  16  burst counter; wraps at 65535.
- trig_timestamp  out  32  scheduled start time of the current burst.
- overrun_pulse  out  1  one-cycle pulse when a burst start is missed.
- busy  out  1  high in SEND or GAP.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; next_trig 0; en_d 0.
- Internal `due` = (signed 32-bit (top_time - next_trig)) >= 0. This comparison is wrap-safe across the 32-bit rollover. Equality with top_time is never used.
- States:
  - IDLE: on cfg_en && !en_d, load next_trig = top_time + OFFSET (mod 2^32) -> WAIT.
  - WAIT: when due -> SEND. Load trig_timestamp = next_trig and frame_idx = 0. Set next_trig += PERIOD.
  - SEND:
    - trig_valid = 1.
    - trig_frame_idx, trig_timestamp and trig_cycle_cnt are held stable while trig_valid && !trig_ready.
    - On trig_ready, the request is accepted in that cycle.
    - If frame_idx == FRAME_NUM-1: trig_cycle_cnt += 1, then -> GAP if GAP > 0, else -> WAIT.
    - Otherwise: frame_idx += 1, then -> GAP if GAP > 0, else stay in SEND with valid held high.
  - GAP:
    - Counter loads GAP-1 on entry; trig_valid = 0 for exactly GAP cycles.
    - On expiry -> SEND for the next frame, or -> WAIT after the last frame of the burst.
- Latency:
  - WAIT->SEND: trig_valid rises the cycle after the first sample where due = 1, i.e. when registered top_time = next_trig + 1.
  - With ready tied high and GAP = 5, successive valid pulses are spaced 6 cycles apart.
- Overrun:
  - Checked while in SEND or GAP: if due becomes true (the next burst start has arrived), pulse overrun_pulse for 1 cycle and advance next_trig += PERIOD.
  - The current burst completes normally.
  - A missed start is skipped, not queued, and does not increment trig_cycle_cnt.
  - Repeated misses pulse once per missed period.
- cfg_en low in any state -> IDLE next cycle.
  - trig_valid drops immediately, abandoning any handshake in progress.
  - trig_cycle_cnt and trig_timestamp hold their values.
- Re-enable re-arms from the current top_time + OFFSET.
- rst mid-burst returns to reset values next cycle, regardless of trig_ready.
- Simultaneous trig_ready acceptance and due on the last frame: the acceptance completes and overrun_pulse fires in the same cycle.
- trig_cycle_cnt wraps 65535 -> 0 with no flag.
- Arithmetic is unsigned modulo 2^32 except for the signed `due` difference.

Test Plan:
- Reset then cfg_en rising at top_time=200, PERIOD=1000, OFFSET=100, FRAME_NUM=4, GAP=5, ready=1 -> trig_timestamp=300, 4 valid pulses, idx 0..3, each 6 cycles apart; the second burst has timestamp 1300 and cycle_cnt=1.
- Backpressure: trig_ready low for 20 cycles on frame 1 -> valid, idx=1 and timestamp stay stable for 20 cycles; after acceptance GAP=5 applies, then idx=2.
- Wrap: cfg_en at top_time=32'hFFFF_FFC0, OFFSET=100 -> burst at top_time=32'h0000_0024, no spurious early trigger.
- Overrun: PERIOD=10, FRAME_NUM=4, GAP=5 -> overrun_pulse once per missed start while the burst runs; missed bursts skipped; cycle_cnt increments only on completed bursts.
- Disable mid-SEND with ready low -> valid=0 next cycle, busy=0, state IDLE; re-enable at top_time=T re-arms to T+OFFSET.
- rst asserted during GAP -> all outputs 0 next cycle; no trig_valid until a new cfg_en rising edge plus OFFSET.
